// File: rtl/axi4l_pkg.sv
// AXI4-Lite shared types: address/data/strobe/prot vectors and response codes.
// Latency: none (types only).
// Backpressure: not applicable.
package axi4l_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [2:0]  prot_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) with master and slave views.
// Latency: none (wires only).
// Backpressure: plain valid/ready on every channel.
interface axi4l_if;
    import axi4l_pkg::*;

    logic  awvalid;
    logic  awready;
    addr_t awaddr;
    prot_t awprot;

    logic  wvalid;
    logic  wready;
    data_t wdata;
    strb_t wstrb;

    logic  bvalid;
    logic  bready;
    resp_t bresp;

    logic  arvalid;
    logic  arready;
    addr_t araddr;
    prot_t arprot;

    logic  rvalid;
    logic  rready;
    data_t rdata;
    resp_t rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4l_dpramx32_ram.sv
// Simple dual-port 32-bit RAM, byte-enable write port, registered read port, no reset.
// Latency: write lands at the edge; read data valid one edge after re.
// Backpressure: none; read register holds its value while re is low.
module dpram_be32 #(
    parameter int aw = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic [aw-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<aw)-1];

    // Byte-lane write; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read; sampling before the write lands gives read-first on collision.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi4l_dpramx32.sv
// AXI4-Lite slave RAM: independent write (AW/W/B) and read (AR/R) ports onto a dual-port RAM.
// Latency: AW+W -> bvalid 2 cycles; AR -> rvalid 2 cycles.
// Backpressure: one address/data slot per channel; commits stall while the response is unaccepted.
module axi4l_dpramx32
    import axi4l_pkg::*;
#(
    parameter int size = 'h10
) (
    input  logic    aclk,
    input  logic    areset,
    axi4l_if.slave  bus
);

    localparam int ram_aw = $clog2(size) - 2;

    logic              aw_full;
    logic              w_full;
    logic              ar_full;
    logic              bvalid_q;
    logic              rvalid_q;
    logic              rd_seen;
    logic [ram_aw-1:0] waddr_q;
    logic [ram_aw-1:0] raddr_q;
    data_t             wdata_q;
    strb_t             wstrb_q;
    data_t             ram_q;
    logic              write_enable;
    logic              read_enable;
    logic              unused;

    // Address bits outside the word index and the prot fields carry no meaning here.
    assign unused = ^{bus.awprot, bus.arprot,
                      bus.awaddr[31:ram_aw+2], bus.awaddr[1:0],
                      bus.araddr[31:ram_aw+2], bus.araddr[1:0]};

    // Handshake readies and commit enables.
    always_comb begin
        bus.awready  = !aw_full;
        bus.wready   = !w_full;
        bus.arready  = !ar_full;
        write_enable = aw_full && w_full && (!bvalid_q || bus.bready);
        read_enable  = ar_full && (!rvalid_q || bus.rready);
    end

    assign bus.bvalid = bvalid_q;
    assign bus.rvalid = rvalid_q;
    assign bus.bresp  = OKAY;
    assign bus.rresp  = OKAY;
    // RAM output register is not reset, so show zero until the first read after reset.
    assign bus.rdata  = rd_seen ? ram_q : '0;

    // Write path: capture AW and W independently, commit once both are held.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (bus.awvalid && !aw_full) begin
                aw_full <= 1'b1;
                waddr_q <= bus.awaddr[ram_aw+1:2];
            end
            if (bus.wvalid && !w_full) begin
                w_full  <= 1'b1;
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (write_enable) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (write_enable)     bvalid_q <= 1'b1;
            else if (bus.bready)  bvalid_q <= 1'b0;
        end
    end

    // Read path: capture AR, issue the RAM read when the R slot is free.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_full  <= 1'b0;
            rvalid_q <= 1'b0;
            rd_seen  <= 1'b0;
            raddr_q  <= '0;
        end else begin
            if (bus.arvalid && !ar_full) begin
                ar_full <= 1'b1;
                raddr_q <= bus.araddr[ram_aw+1:2];
            end
            if (read_enable) begin
                ar_full <= 1'b0;
                rd_seen <= 1'b1;
            end
            if (read_enable)      rvalid_q <= 1'b1;
            else if (bus.rready)  rvalid_q <= 1'b0;
        end
    end

    dpram_be32 #(.aw(ram_aw)) u_ram (
        .clk   (aclk),
        .we    (write_enable),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .re    (read_enable),
        .raddr (raddr_q),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi4l_dpramx32.sv
// Directed bench for axi4l_dpramx32 with B/R scoreboard queues.
// Latency: checks 2-cycle write and read response timing.
// Backpressure: exercises bready/rready stalls and slot-full readies.
module tb_axi4l_dpramx32;
    import axi4l_pkg::*;

    logic aclk;
    logic areset;
    axi4l_if bus();

    axi4l_dpramx32 #(.size('h10)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    resp_t b_q[$];
    data_t r_q[$];

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Response monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge aclk) begin
        if (!areset && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else chk("bresp", bus.bresp, b_q.pop_front());
        end
        if (!areset && bus.rvalid && bus.rready) begin
            if (r_q.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
            else begin
                chk("rdata", bus.rdata, r_q.pop_front());
                chk("rresp", bus.rresp, OKAY);
            end
        end
    end

    task automatic do_write(input addr_t a, input data_t d, input strb_t s);
        bit aw_done = 0;
        bit w_done  = 0;
        bit a_hs;
        bit w_hs;
        b_q.push_back(OKAY);
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
        for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
            @(negedge aclk);
            a_hs = bus.awvalid && bus.awready;
            w_hs = bus.wvalid && bus.wready;
            tick();
            if (a_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs) begin w_done  = 1; bus.wvalid  = 1'b0; end
        end
        chk("write_handshake", {30'd0, aw_done, w_done}, 32'd3);
    endtask

    task automatic do_read(input addr_t a, input data_t exp);
        bit done = 0;
        bit hs;
        r_q.push_back(exp);
        bus.arvalid = 1'b1; bus.araddr = a;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            hs = bus.arvalid && bus.arready;
            tick();
            if (hs) begin done = 1; bus.arvalid = 1'b0; end
        end
        chk("read_handshake", {31'd0, done}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (b_q.size() + r_q.size()) != 0; i++) tick();
        chk("drain", b_q.size() + r_q.size(), 32'd0);
    endtask

    initial begin
        areset = 1'b1;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.bready  = 1'b1; bus.rready = 1'b1;
        repeat (3) tick();
        chk("rst_awready", bus.awready, 1);
        chk("rst_wready",  bus.wready,  1);
        chk("rst_arready", bus.arready, 1);
        chk("rst_bvalid",  bus.bvalid,  0);
        chk("rst_rvalid",  bus.rvalid,  0);
        chk("rst_rdata",   bus.rdata,   0);
        chk("rst_bresp",   bus.bresp,   OKAY);
        areset = 1'b0;
        tick();
        chk("rel_awready", bus.awready, 1);
        chk("rel_bvalid",  bus.bvalid,  0);

        // Write latency: AW+W same cycle, bvalid two edges later.
        b_q.push_back(OKAY);
        bus.awvalid = 1'b1; bus.awaddr = 32'h4;
        bus.wvalid  = 1'b1; bus.wdata  = 32'hDEADBEEF; bus.wstrb = 4'hF;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("wlat_c1_bvalid", bus.bvalid, 0);
        tick();
        chk("wlat_c2_bvalid", bus.bvalid, 1);
        chk("wlat_c2_bresp",  bus.bresp,  OKAY);

        // Read latency: AR -> rvalid two edges later.
        r_q.push_back(32'hDEADBEEF);
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        tick();
        bus.arvalid = 1'b0;
        chk("rlat_c1_rvalid", bus.rvalid, 0);
        tick();
        chk("rlat_c2_rvalid", bus.rvalid, 1);
        chk("rlat_c2_rdata",  bus.rdata,  32'hDEADBEEF);
        drain();

        // Byte strobes.
        do_write(32'h8, 32'h11223344, 4'hF);
        do_write(32'h8, 32'hAABBCCDD, 4'b0101);
        drain();
        do_read(32'h8, 32'h11BB33DD);
        drain();

        // W three cycles ahead of AW, B stalled.
        bus.bready = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'h01020304; bus.wstrb = 4'hF;
        tick();
        bus.wvalid = 1'b0;
        chk("wfirst_wready", bus.wready, 0);
        tick();
        tick();
        chk("wfirst_no_b", bus.bvalid, 0);
        b_q.push_back(OKAY);
        bus.awvalid = 1'b1; bus.awaddr = 32'h0;
        tick();
        bus.awvalid = 1'b0;
        tick();
        chk("wfirst_bvalid", bus.bvalid, 1);
        // Second AW+W accepted while B pends.
        b_q.push_back(OKAY);
        bus.awvalid = 1'b1; bus.awaddr = 32'h4;
        bus.wvalid  = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        tick();
        chk("stall_awready_full", bus.awready, 0);
        chk("stall_wready_full",  bus.wready,  0);
        chk("stall_bvalid0", bus.bvalid, 1);
        // Third AW+W (empty strobe) must wait for the first B handshake.
        b_q.push_back(OKAY);
        bus.awaddr = 32'h8; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_bvalid", bus.bvalid, 1);
            chk("stall_bresp",  bus.bresp,  OKAY);
            chk("stall_awready", bus.awready, 0);
        end
        bus.bready = 1'b1;
        tick();
        chk("after_b_awready", bus.awready, 1);
        chk("after_b_bvalid",  bus.bvalid,  1);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        drain();

        // R stalled with a second AR queued.
        bus.rready = 1'b0;
        r_q.push_back(32'h01020304);
        bus.arvalid = 1'b1; bus.araddr = 32'h0;
        tick();
        bus.arvalid = 1'b0;
        tick();
        chk("rstall_rvalid", bus.rvalid, 1);
        chk("rstall_rdata0", bus.rdata, 32'h01020304);
        r_q.push_back(32'hCAFEF00D);
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        tick();
        bus.arvalid = 1'b0;
        chk("rstall_arready", bus.arready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstall_hold", bus.rdata, 32'h01020304);
        end
        bus.rready = 1'b1;
        tick();
        chk("rstall_second", bus.rdata, 32'hCAFEF00D);
        tick();
        chk("rstall_done", bus.rvalid, 0);
        do_read(32'h8, 32'h11BB33DD);
        drain();

        // Aliasing above size.
        do_write(32'h10, 32'h00000055, 4'hF);
        drain();
        do_read(32'h0, 32'h00000055);
        drain();

        // Same-word read/write collision returns old data.
        do_write(32'hC, 32'h12345678, 4'hF);
        drain();
        b_q.push_back(OKAY);
        r_q.push_back(32'h12345678);
        bus.awvalid = 1'b1; bus.awaddr = 32'hC;
        bus.wvalid  = 1'b1; bus.wdata = 32'h9ABCDEF0; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 32'hC;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        tick();
        chk("collide_old", bus.rdata, 32'h12345678);
        drain();
        do_read(32'hC, 32'h9ABCDEF0);
        drain();

        // Reset with B pending, R pending and AR slot full.
        bus.bready = 1'b0; bus.rready = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 32'h8;
        bus.wvalid  = 1'b1; bus.wdata = 32'h77777777; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 32'h0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        tick();
        chk("pre_rst_bvalid", bus.bvalid, 1);
        chk("pre_rst_rdata",  bus.rdata,  32'h00000055);
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        tick();
        bus.arvalid = 1'b0;
        chk("pre_rst_arready", bus.arready, 0);
        areset = 1'b1;
        #1;
        chk("mid_rst_bvalid",  bus.bvalid,  0);
        chk("mid_rst_rvalid",  bus.rvalid,  0);
        chk("mid_rst_awready", bus.awready, 1);
        chk("mid_rst_wready",  bus.wready,  1);
        chk("mid_rst_arready", bus.arready, 1);
        chk("mid_rst_rdata",   bus.rdata,   0);
        tick();
        tick();
        areset = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        do_read(32'h8, 32'h77777777);
        do_read(32'h4, 32'hCAFEF00D);
        do_read(32'h0, 32'h00000055);
        do_read(32'hC, 32'h9ABCDEF0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
